// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift sequencer.
package shift_pkg;

   localparam int unsigned WIDTH_C = 24;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ILL = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves din by 0..STEP bits left or right,
// filling vacated high bits with 'fill' on right shifts.
module shift_step
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_C,
   parameter int unsigned STEP  = 8
) (
   input  logic [WIDTH-1:0] din,
   input  logic [4:0]       amt,
   input  logic             right,
   input  logic             fill,
   output logic [WIDTH-1:0] dout
);

   logic [2*WIDTH-1:0] ext;

   // Prepending WIDTH fill bits makes a logical right shift behave as a sign fill.
   always_comb begin
      ext  = {{WIDTH{fill}}, din} >> amt;
      dout = right ? ext[WIDTH-1:0] : (din << amt);
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle 24-bit SLL/SRL/SRA controller: iterates a narrow step shifter
// until the requested (saturated) amount is consumed, then holds the result.
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_C,
   parameter int unsigned STEP  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [3:0]       in_shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_err,
   output logic             busy
);

   state_e           state;
   op_e              op;
   op_e              req_op;
   logic [4:0]       rem;
   logic [4:0]       rem_init;
   logic [4:0]       step;
   logic [4:0]       rem_next;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] stepped;
   logic [WIDTH:0]   amount;
   logic             fill;
   logic             right;
   logic             req_ill;

   assign req_op  = op_e'(in_op);
   assign req_ill = (req_op == OP_ILL);

   // Carry of the 24-bit add lands in bit 24 so large register amounts still saturate.
   assign amount   = {1'b0, in_b} + {{(WIDTH-3){1'b0}}, in_shamt};
   assign rem_init = (amount >= (WIDTH+1)'(WIDTH)) ? 5'(WIDTH) : amount[4:0];

   assign step     = (rem < 5'(STEP)) ? rem : 5'(STEP);
   assign rem_next = rem - step;
   assign right    = (op != OP_SLL);

   shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_step (
      .din   (work),
      .amt   (step),
      .right (right),
      .fill  (fill),
      .dout  (stepped)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         op         <= OP_SLL;
         rem        <= '0;
         work       <= '0;
         fill       <= 1'b0;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_err    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op       <= req_op;
                  work     <= in_a;
                  fill     <= (req_op == OP_SRA) && in_a[WIDTH-1];
                  rem      <= rem_init;
                  out_err  <= req_ill;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (!req_ill && rem_init != '0) begin
                     state <= SHIFT;
                  end else begin
                     state      <= DONE;
                     out_valid  <= 1'b1;
                     out_result <= in_a;
                  end
               end
            end
            SHIFT: begin
               work <= stepped;
               rem  <= rem_next;
               if (rem_next == '0) begin
                  state      <= DONE;
                  out_valid  <= 1'b1;
                  out_result <= stepped;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with hand-computed results and latencies.
module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [23:0] in_a;
   logic [23:0] in_b;
   logic [3:0]  in_shamt;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_result;
   logic        out_err;
   logic        busy;

   int unsigned checks = 0;
   int unsigned errors = 0;

   shift_sequencer #(
      .WIDTH (24),
      .STEP  (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_shamt   (in_shamt),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_err    (out_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one request, measure cycles to out_valid, check result, then complete the handshake.
   task automatic run(input string tag, input logic [1:0] op, input logic [23:0] a,
                      input logic [23:0] b, input logic [3:0] sh,
                      input logic [23:0] exp_res, input logic exp_err, input int unsigned exp_lat);
      int unsigned lat;
      @(negedge clk);
      check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_shamt = sh;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      check({tag, ".result"}, 32'(out_result), 32'(exp_res));
      check({tag, ".err"}, 32'(out_err), 32'(exp_err));
      check({tag, ".busy"}, 32'(busy), 32'd1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, ".drop"}, {29'd0, out_valid, in_ready, busy}, 32'b010);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned lat;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 2'b00;
      in_a      = '0;
      in_b      = '0;
      in_shamt  = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset.flags", {28'd0, in_ready, out_valid, out_err, busy}, 32'b1000);
      check("reset.result", 32'(out_result), 32'd0);
      rst_n = 1'b1;

      run("sll5",   2'b00, 24'h000001, 24'd0,      4'd5,  24'h000020, 1'b0, 2);
      run("sra23",  2'b10, 24'h800000, 24'd20,     4'd3,  24'hFFFFFF, 1'b0, 4);
      run("sllsat", 2'b00, 24'hABCDEF, 24'h000020, 4'd0,  24'h000000, 1'b0, 4);
      run("srasat", 2'b10, 24'h900000, 24'h000020, 4'd0,  24'hFFFFFF, 1'b0, 4);
      run("srl24",  2'b01, 24'h7FFFFF, 24'd24,     4'd0,  24'h000000, 1'b0, 4);
      run("sra24p", 2'b10, 24'h7FFFFF, 24'd24,     4'd0,  24'h000000, 1'b0, 4);
      run("carry",  2'b01, 24'h123456, 24'hFFFFFF, 4'd15, 24'h000000, 1'b0, 4);
      run("sll16",  2'b00, 24'h0000FF, 24'd16,     4'd0,  24'hFF0000, 1'b0, 3);
      run("sll23",  2'b00, 24'h000001, 24'd20,     4'd3,  24'h800000, 1'b0, 4);
      run("sra9",   2'b10, 24'hC00000, 24'd1,      4'd8,  24'hFFE000, 1'b0, 3);
      run("amt0",   2'b00, 24'h5A5A5A, 24'd0,      4'd0,  24'h5A5A5A, 1'b0, 1);
      run("ill",    2'b11, 24'h123456, 24'd3,      4'd2,  24'h123456, 1'b1, 1);
      run("clrerr", 2'b01, 24'h000100, 24'd0,      4'd8,  24'h000001, 1'b0, 2);

      // Backpressure: result must hold and new requests must be ignored.
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = 2'b01;
      in_a     = 24'hF00000;
      in_b     = 24'd0;
      in_shamt = 4'd4;
      @(posedge clk);
      #1;
      in_op    = 2'b00;
      in_a     = 24'h000001;
      in_shamt = 4'd1;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("hold.lat", 32'(lat), 32'd2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold.state", {29'd0, out_valid, in_ready, busy}, 32'b101);
         check("hold.result", 32'(out_result), 32'h0F0000);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("hold.drop", {29'd0, out_valid, in_ready, busy}, 32'b010);
      repeat (3) @(posedge clk);
      #1;
      check("hold.ignored", {30'd0, out_valid, busy}, 32'b00);

      // Reset in the middle of an SRA by 20 discards the operation.
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = 2'b10;
      in_a     = 24'h800000;
      in_b     = 24'd20;
      in_shamt = 4'd0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("abort.busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("abort.flags", {28'd0, in_ready, out_valid, out_err, busy}, 32'b1000);
      check("abort.result", 32'(out_result), 32'd0);
      lat = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) lat++;
      end
      check("abort.noout", 32'(lat), 32'd0);
      run("after", 2'b00, 24'h000003, 24'd1, 4'd0, 24'h000006, 1'b0, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle controller that sequences 24-bit logical/arithmetic shifts through a narrow per-cycle step shifter instead of a full barrel shifter. Sits beside the ALU in the execute stage. It accepts an operand, a base amount register and an immediate SHAMT over a valid/ready handshake, and iterates shift steps until done. It presents a registered result over a second valid/ready handshake to writeback.

Parameters:
WIDTH, 24, datapath width (fixed by the CPU; other values are unsupported)
STEP, 8, maximum shift distance per cycle; power of two, 1..16

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-low reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 illegal
in_a  in  WIDTH  operand to shift
in_b  in  WIDTH  base shift amount (register operand)
in_shamt  in  4  immediate shift amount
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  WIDTH  shifted value
out_err  out  1  request carried illegal op
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (Reset==0 at a rising edge): state IDLE. in_ready=1, out_valid=0, out_result=0, out_err=0, busy=0. Reset aborts any in-flight operation with no output. Reset takes priority over all other inputs.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, capture in_op, in_a and the amount in the same edge.
  - amount = {20'b0,in_shamt} + in_b, computed 25 bits wide so carry is not lost.
  - Saturate: if amount >= 24, set rem = 24 and apply the fill rule below; otherwise rem = amount[4:0].
  - Next state is SHIFT if rem != 0 and op is legal, else DONE.
- Saturation fill: SLL/SRL give 0. SRA gives 24 copies of in_a[23].
- SHIFT: each cycle, step = min(rem, STEP). The working value is shifted by step and rem -= step.
  - SLL and SRL zero-fill. SRA sign-fills from the original in_a[23].
  - When rem reaches 0, go to DONE on the next edge.
  - in_ready=0.
- Latency: start handshake at cycle 0. Cycles 1..N are SHIFT, with N = ceil(rem/STEP); for STEP=8, N is at most 3. out_valid rises at cycle N+1.
  - Amount 0 or illegal op: DONE at cycle 1.
- DONE: out_valid=1. out_result holds the final value and stays stable until the handshake.
  - On out_valid&out_ready, go to IDLE and drop out_valid on the next edge.
  - in_ready=0 in DONE; there is no same-cycle accept, so the minimum gap is 1 cycle.
- Illegal op (11): out_result = in_a unchanged, out_err=1. out_err is cleared at the next accepted request.
- in_valid while not in IDLE is ignored. Requesters must hold their inputs until in_ready.
- out_ready is ignored outside DONE.
- Cumulative shift of 24 or more under SLL/SRL gives 0; this is reached only through saturation.

Decomposition:
- Shared package shift_pkg holds: op encodings (OP_SLL, OP_SRL, OP_SRA, OP_ILL), the state enum (IDLE, SHIFT, DONE), and WIDTH_C=24.
- One sub-module, shift_step: combinational shift of WIDTH bits by 0..STEP with a direction input and a fill-bit input. Built from the existing 24-bit mux cells.
- The sequencer holds the FSM, the rem counter, the working register and the output register.
- The 25-bit amount adder reuses the existing 24-bit adder, with its carry-out as bit 24.

Test Plan:
- SLL, a=0x000001, b=0, shamt=5: 1 SHIFT cycle; out_valid at cycle 2; result 0x000020; err=0.
- SRA, a=0x800000, b=20, shamt=3 (amount 23): 3 SHIFT cycles (8,8,7); out_valid at cycle 4; result 0xFFFFFF.
- SLL, a=0xABCDEF, b=0x000020, shamt=0 (amount 32, saturated): result 0x000000. SRA with a=0x900000 and the same amount: result 0xFFFFFF.
- SRL, a=0xF00000, b=0, shamt=4, with out_ready held 0 for 5 cycles:
  - result 0x0F0000 stays stable with out_valid=1 throughout;
  - in_ready stays 0;
  - a new in_valid is ignored until after the handshake.
- Reset asserted at cycle 2 of an SRA with amount 20: next cycle is IDLE, in_ready=1, out_valid=0, and no result is emitted. A following SLL a=0x000003, amount 1 gives 0x000006.
- Illegal op 11, a=0x123456: out_valid at cycle 1, result 0x123456, out_err=1. The next legal request clears out_err.
